// File: rtl/adder_seq_ctrl.sv
// Nibble-serial adder: one shared 4-bit slice computes A + B + Cin over NIBBLES cycles.
// Define ADDER_SEQ_OVF_EN to add the signed-overflow output ovf_o.

module full_adder_4bit (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       c_i,
    output logic [3:0] s_o,
    output logic       c_o
);

    assign {c_o, s_o} = 5'(a_i) + 5'(b_i) + 5'(c_i);

endmodule

module adder_seq_ctrl #(
    parameter int unsigned NIBBLES = 4,
    localparam int unsigned W      = 4 * NIBBLES
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [W-1:0] A_i,
    input  logic [W-1:0] B_i,
    input  logic         C_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] S_o,
    output logic         C_o,
    output logic         busy_o
`ifdef ADDER_SEQ_OVF_EN
    ,
    output logic         ovf_o
`endif
);

    localparam int unsigned IdxW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    if (NIBBLES < 2 || NIBBLES > 8) begin : gen_bad_nibbles
        $error("adder_seq_ctrl: NIBBLES must be in 2..8");
    end

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [W-1:0]      a_q, a_d;
    logic [W-1:0]      b_q, b_d;
    logic [W-1:0]      sum_q, sum_d;
    logic              carry_q, carry_d;
    logic              cout_q, cout_d;
    logic [IdxW-1:0]   idx_q, idx_d;

    logic [3:0]        slice_a;
    logic [3:0]        slice_b;
    logic [3:0]        slice_s;
    logic              slice_co;
    logic              last_nibble;

`ifdef ADDER_SEQ_OVF_EN
    logic              ovf_q, ovf_d;
`endif

    assign slice_a     = a_q[4*idx_q +: 4];
    assign slice_b     = b_q[4*idx_q +: 4];
    assign last_nibble = (idx_q == IdxW'(NIBBLES - 1));

    full_adder_4bit u_slice (
        .a_i (slice_a),
        .b_i (slice_b),
        .c_i (carry_q),
        .s_o (slice_s),
        .c_o (slice_co)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        idx_d   = idx_q;
`ifdef ADDER_SEQ_OVF_EN
        ovf_d   = ovf_q;
`endif

        unique case (state_q)
            StIdle: begin
                if (in_valid_i) begin
                    a_d     = A_i;
                    b_d     = B_i;
                    carry_d = C_i;
                    idx_d   = '0;
                    state_d = StCalc;
                end
            end

            StCalc: begin
                sum_d[4*idx_q +: 4] = slice_s;
                carry_d             = slice_co;
                if (last_nibble) begin
                    idx_d   = '0;
                    cout_d  = slice_co;
`ifdef ADDER_SEQ_OVF_EN
                    // Carry into the MSB is recovered from the MSB's own sum bit.
                    ovf_d   = slice_a[3] ^ slice_b[3] ^ slice_s[3] ^ slice_co;
`endif
                    state_d = StDone;
                end else begin
                    idx_d = idx_q + IdxW'(1);
                end
            end

            StDone: begin
                if (out_ready_i) begin
                    state_d = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            idx_q   <= idx_d;
        end
    end

`ifdef ADDER_SEQ_OVF_EN
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf_o = ovf_q;
`endif

    assign in_ready_o  = (state_q == StIdle);
    assign out_valid_o = (state_q == StDone);
    assign busy_o      = (state_q == StCalc);
    assign S_o         = sum_q;
    assign C_o         = cout_q;

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Scoreboard bench for adder_seq_ctrl: directed vectors, queued expectations, negedge monitor.

module tb_adder_seq_ctrl;

    localparam int NIBBLES = 4;
    localparam int W       = 4 * NIBBLES;

    logic         clk       = 1'b0;
    logic         rst_n     = 1'b0;
    logic         in_valid  = 1'b0;
    logic         out_ready = 1'b1;
    logic [W-1:0] a         = '0;
    logic [W-1:0] b         = '0;
    logic         cin       = 1'b0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;
    logic         ovf;

    adder_seq_ctrl #(
        .NIBBLES (NIBBLES)
    ) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .A_i         (a),
        .B_i         (b),
        .C_i         (cin),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .S_o         (sum),
        .C_o         (cout),
        .busy_o      (busy)
`ifdef ADDER_SEQ_OVF_EN
        ,
        .ovf_o       (ovf)
`endif
    );

`ifndef ADDER_SEQ_OVF_EN
    assign ovf = 1'b0;
`endif

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] s;
        logic         c;
        logic         o;
        int           acc;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: latency on rising valid, hold checks while stalled, compare+pop on handshake.
    logic prev_valid = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid = 1'b0;
        end else begin
            if (out_valid && !prev_valid) begin
                if (sb.size() == 0) chk("unexpected_valid", 32'(out_valid), 0);
                else chk("latency", 32'(cyc - sb[0].acc), NIBBLES);
            end
            if (out_valid && sb.size() > 0) begin
                if (out_ready) begin
                    chk("sum", 32'(sum), 32'(sb[0].s));
                    chk("cout", 32'(cout), 32'(sb[0].c));
`ifdef ADDER_SEQ_OVF_EN
                    chk("ovf", 32'(ovf), 32'(sb[0].o));
`endif
                    void'(sb.pop_front());
                end else begin
                    chk("hold_sum", 32'(sum), 32'(sb[0].s));
                    chk("hold_in_ready", 32'(in_ready), 0);
                end
            end
            prev_valid = out_valid;
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!in_ready) chk("ready_timeout", 32'(in_ready), 1);
    endtask

    task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc,
                        input logic push, input logic [W-1:0] es, input logic ec,
                        input logic eo);
        exp_t e;
        wait_ready();
        a        = ta;
        b        = tb_v;
        cin      = tc;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        // Scramble operands after acceptance; result must not change.
        a        = ~ta;
        b        = ~tb_v;
        cin      = ~tc;
        if (push) begin
            e.s   = es;
            e.c   = ec;
            e.o   = eo;
            e.acc = cyc;
            sb.push_back(e);
        end
        chk("busy_after_accept", 32'(busy), 1);
        chk("in_ready_in_calc", 32'(in_ready), 0);
    endtask

    task automatic check_idle_zero(input string tag);
        chk({tag, "_in_ready"}, 32'(in_ready), 1);
        chk({tag, "_out_valid"}, 32'(out_valid), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_sum"}, 32'(sum), 0);
        chk({tag, "_cout"}, 32'(cout), 0);
`ifdef ADDER_SEQ_OVF_EN
        chk({tag, "_ovf"}, 32'(ovf), 0);
`endif
    endtask

    initial begin
        logic seen;
        int   n;

        #12;
        check_idle_zero("reset");

        // First acceptance on the first rising edge after release.
        @(negedge clk);
        rst_n = 1'b1;
        send(16'h000A, 16'h0005, 1'b0, 1'b1, 16'h000F, 1'b0, 1'b0);
        send(16'hFFFF, 16'h0001, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);
        send(16'h7FFF, 16'h0000, 1'b1, 1'b1, 16'h8000, 1'b0, 1'b1);
        send(16'h1234, 16'h4321, 1'b1, 1'b1, 16'h5556, 1'b0, 1'b0);
        send(16'h8000, 16'h8000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b1);
        send(16'h0F0F, 16'h00F1, 1'b0, 1'b1, 16'h1000, 1'b0, 1'b0);

        // Stalled result with a second in_valid that must be ignored.
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        out_ready = 1'b0;
        send(16'h0003, 16'h0007, 1'b0, 1'b1, 16'h000A, 1'b0, 1'b0);
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("hold_valid_seen", 32'(out_valid), 1);
        in_valid = 1'b1;
        a        = 16'h1111;
        b        = 16'h2222;
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("release_in_ready", 32'(in_ready), 1);
        chk("release_out_valid", 32'(out_valid), 0);
        chk("retain_sum", 32'(sum), 32'h000A);
        chk("retain_cout", 32'(cout), 0);

        // Reset during the second CALC cycle aborts the operation.
        send(16'h1111, 16'h2222, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_idle_zero("abort");
        @(negedge clk);
        rst_n = 1'b1;
        seen  = 1'b0;
        repeat (10) begin
            @(posedge clk);
            #1;
            seen = seen | out_valid;
        end
        chk("abort_no_valid", 32'(seen), 0);

        send(16'h0002, 16'h0003, 1'b0, 1'b1, 16'h0005, 1'b0, 1'b0);

        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("queue_drained", 32'(sb.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
